// File: rtl/rca_pkg.sv
// rca_pkg: shared types, defaults and width helper for the ripple-carry accumulator
package rca_pkg;
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_NUM_OPS = 4;
  function automatic int cw_of(input int num_ops);
    return (num_ops > 1) ? $clog2(num_ops) : 1;
  endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/rca_nbit.sv
// rca_nbit: WIDTH-bit ripple-carry adder built from a chain of full_adder cells
module rca_nbit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] c;
  assign c[0] = cin;
  assign cout = c[WIDTH];
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (.a(a[i]), .b(b[i]), .cin(c[i]), .sum(sum[i]), .cout(c[i+1]));
  end
endmodule

// File: rtl/rca_accumulator.sv
// rca_accumulator: sums groups of NUM_OPS operands, counting carry-outs into extended upper bits
module rca_accumulator
  import rca_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_OPS = DEF_NUM_OPS
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH+cw_of(NUM_OPS)-1:0]  out_sum,
  output logic                             out_ovf
);
  localparam int CW = cw_of(NUM_OPS);
  state_t state, state_n;
  logic [WIDTH-1:0] acc, acc_n, sum;
  logic [CW-1:0] carry_cnt, carry_cnt_n, op_cnt, op_cnt_n;
  logic ovf, ovf_n, cout, live;
  rca_nbit #(.WIDTH(WIDTH)) u_add (.a(acc), .b(in_data), .cin(1'b0), .sum(sum), .cout(cout));
  // live keeps in_ready low until the first clock after reset release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ACCUM;
      acc <= '0;
      carry_cnt <= '0;
      op_cnt <= '0;
      ovf <= 1'b0;
      live <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      carry_cnt <= carry_cnt_n;
      op_cnt <= op_cnt_n;
      ovf <= ovf_n;
      live <= 1'b1;
    end
  always_comb begin
    state_n = state;
    acc_n = acc;
    carry_cnt_n = carry_cnt;
    op_cnt_n = op_cnt;
    ovf_n = ovf;
    in_ready = live && (state == ACCUM);
    out_valid = (state == HOLD);
    if (clr) begin
      state_n = ACCUM;
      acc_n = '0;
      carry_cnt_n = '0;
      op_cnt_n = '0;
      ovf_n = 1'b0;
    end else if (state == ACCUM) begin
      if (in_valid && in_ready) begin
        acc_n = sum;
        carry_cnt_n = carry_cnt + CW'(cout);
        ovf_n = ovf | cout;
        op_cnt_n = (op_cnt == CW'(NUM_OPS - 1)) ? '0 : op_cnt + 1'b1;
        state_n = (op_cnt == CW'(NUM_OPS - 1)) ? HOLD : ACCUM;
      end
    end else if (out_ready) begin
      state_n = ACCUM;
      acc_n = '0;
      carry_cnt_n = '0;
      ovf_n = 1'b0;
    end
  end
  assign out_sum = {carry_cnt, acc};
  assign out_ovf = ovf;
endmodule
